// File: rtl/top.sv
// Radix-4 (Booth-2) signed 4x4 multiplier, three-stage free-running pipeline:
// operand register, Booth partial-product register, sum register.
module top (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] multiplicand,
   input  logic [3:0] multiplier,
   output logic [7:0] final_result
);

   logic signed [3:0] x_q, x_d;
   logic signed [3:0] y_q, y_d;
   logic signed [7:0] pp0_q, pp0_d;
   logic signed [7:0] pp1_q, pp1_d;
   logic signed [7:0] res_q, res_d;
   logic signed [7:0] x_ext;

   // Booth-2 group {b2,b1,b0} selects a multiple of X in {-2,-1,0,+1,+2}.
   function automatic logic signed [7:0] booth_pp(input logic [2:0]        grp,
                                                  input logic signed [7:0] x);
      logic signed [7:0] pp;
      case (grp)
         3'b001, 3'b010: pp = x;
         3'b011:         pp = x <<< 1;
         3'b100:         pp = -(x <<< 1);
         3'b101, 3'b110: pp = -x;
         default:        pp = '0;
      endcase
      return pp;
   endfunction

   // Stage 1: operand capture
   always_comb begin
      x_d = multiplicand;
      y_d = multiplier;
   end

   // Stage 2: partial products; X is widened first so -2*(-8) fits as +16
   always_comb begin
      x_ext = {{4{x_q[3]}}, x_q};
      pp0_d = booth_pp({y_q[1], y_q[0], 1'b0}, x_ext);
      pp1_d = booth_pp({y_q[3], y_q[2], y_q[1]}, x_ext) <<< 2;
   end

   // Stage 3: final sum
   always_comb begin
      res_d = pp0_q + pp1_q;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         x_q   <= '0;
         y_q   <= '0;
         pp0_q <= '0;
         pp1_q <= '0;
         res_q <= '0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         pp0_q <= pp0_d;
         pp1_q <= pp1_d;
         res_q <= res_d;
      end
   end

   assign final_result = res_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the Booth-2 multiplier: directed scenarios, exhaustive
// back-to-back sweep and random pairs against a sampled-product history model.
module tb_top;

   logic       CLK;
   logic       RST;
   logic [3:0] multiplicand;
   logic [3:0] multiplier;
   logic [7:0] final_result;

   int checks   = 0;
   int failures = 0;

   // Products of the operands sampled at each rising edge since reset release.
   logic [7:0] hist[$];
   int         n_edges = 0;

   top dut (
      .CLK          (CLK),
      .RST          (RST),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .final_result (final_result)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_prod(input logic [3:0] x, input logic [3:0] y);
      int xi, yi, p;
      xi = (x >= 4'd8) ? int'(x) - 16 : int'(x);
      yi = (y >= 4'd8) ? int'(y) - 16 : int'(y);
      p  = xi * yi;
      return p[7:0];
   endfunction

   // Drive a pair, take one rising edge, check the output 1 time unit later.
   task automatic cycle(input logic [3:0] x, input logic [3:0] y, input string tag);
      logic [7:0] exp;
      multiplicand = x;
      multiplier   = y;
      @(posedge CLK);
      if (!RST) begin
         hist.delete();
         n_edges = 0;
         exp     = 8'h00;
      end else begin
         hist.push_back(ref_prod(x, y));
         n_edges++;
         exp = (n_edges >= 3) ? hist[n_edges - 3] : 8'h00;
      end
      #1;
      check(tag, final_result, exp);
   endtask

   initial begin
      RST          = 1'b0;
      multiplicand = 4'h0;
      multiplier   = 4'h0;
      #1;
      check("reset_async_initial", final_result, 8'h00);

      for (int i = 0; i < 4; i++)
         cycle(4'($urandom), 4'($urandom), "reset_held");

      #2 RST = 1'b1;

      repeat (3) cycle(4'hB, 4'h9, "m5_x_m7");
      check("m5_x_m7_literal", final_result, 8'h23);
      cycle(4'hB, 4'h9, "m5_x_m7_hold");
      check("m5_x_m7_hold_literal", final_result, 8'h23);

      repeat (3) cycle(4'h6, 4'hD, "6_x_m3");
      check("6_x_m3_literal", final_result, 8'hEE);
      repeat (3) cycle(4'hC, 4'hF, "m4_x_m1");
      check("m4_x_m1_literal", final_result, 8'h04);

      repeat (3) cycle(4'h8, 4'h8, "m8_x_m8");
      check("m8_x_m8_literal", final_result, 8'h40);
      repeat (3) cycle(4'h7, 4'h8, "7_x_m8");
      check("7_x_m8_literal", final_result, 8'hC8);
      repeat (3) cycle(4'h8, 4'h7, "m8_x_7");
      check("m8_x_7_literal", final_result, 8'hC8);
      repeat (3) cycle(4'h0, 4'h5, "0_x_5");
      check("0_x_5_literal", final_result, 8'h00);

      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = 8'(i);
         cycle(v[7:4], v[3:0], "sweep");
      end

      for (int i = 0; i < 300; i++)
         cycle(4'($urandom), 4'($urandom), "random");

      cycle(4'h7, 4'h7, "inflight_a");
      cycle(4'h9, 4'h3, "inflight_b");
      #2 RST = 1'b0;
      #1;
      check("reset_midflight_async", final_result, 8'h00);
      for (int i = 0; i < 3; i++)
         cycle(4'($urandom), 4'($urandom), "reset_midflight_held");
      #2 RST = 1'b1;

      cycle(4'h5, 4'h6, "recover_e1");
      cycle(4'hA, 4'h3, "recover_e2");
      cycle(4'h7, 4'h7, "recover_e3");
      check("recover_e3_literal", final_result, 8'h1E);
      cycle(4'h7, 4'h7, "recover_e4");
      check("recover_e4_literal", final_result, 8'hEE);
      for (int i = 0; i < 50; i++)
         cycle(4'($urandom), 4'($urandom), "random_post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The module SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port multiplicand, input, 4 bits: signed two's-complement operand X, range -8..7.
REQ-004 The module SHALL have port multiplier, input, 4 bits: signed two's-complement operand Y, range -8..7.
REQ-005 The module SHALL have port final_result, output, 8 bits: registered signed two's-complement product X*Y.
REQ-006 The module SHALL have no parameters; all widths are fixed.

Function
REQ-007 Multiplication SHALL use the radix-4 (Booth-2) algorithm, not a behavioural '*' operator.
REQ-008 Pipeline stage 1 SHALL register multiplicand and multiplier on every rising CLK edge (free-running, no handshake).
REQ-009 Stage 2 SHALL Booth-encode the registered Y with implicit Y[-1]=0: group0={Y1,Y0,0}, group1={Y3,Y2,Y1}; digit = -2*b2 + b1 + b0, giving a value in {-2,-1,0,+1,+2}.
REQ-010 Each digit SHALL select a partial product: 0, +X, -X, +2X or -2X. X SHALL be sign-extended to 8 bits before the shift or negation. Negation SHALL be two's complement.
REQ-011 Stage 2 SHALL register PP0 = digit0 x X and PP1 = (digit1 x X) << 2, both 8 bits.
REQ-012 Stage 3 SHALL register final_result = (PP0 + PP1) mod 2^8.
REQ-013 The result SHALL equal the exact signed product for all 256 operand pairs. The range is -56..64, so no overflow is possible.
REQ-014 Latency SHALL be 3 rising edges: operands sampled at edge k appear on final_result after edge k+2.
REQ-015 Throughput SHALL be one product per clock. Operand changes on consecutive cycles SHALL each produce their own correct result, in order.
REQ-016 final_result SHALL hold its value while the inputs are unchanged. Between updates it SHALL show no glitches, as it comes directly from a register.
REQ-017 Corner operands SHALL be exact: X=-8 with digit -2 gives +16 before the shift, held correctly in 8 bits; -8 x -8 = +64 (0x40).

Reset
REQ-018 While RST=0, all pipeline registers and final_result SHALL be 0x00, immediately and independently of CLK.
REQ-019 RST asserted mid-operation SHALL discard all in-flight products. No stale value SHALL appear on final_result after RST is released.
REQ-020 After RST rises, the first rising edge SHALL sample the operands. final_result SHALL become valid after the 3rd edge; until then it reads 0x00.
REQ-021 Multiplying by zero SHALL yield 0x00, indistinguishable from the reset value; this is acceptable.

Verification
REQ-022 Scenario: RST=0 with any operands and the clock running -> final_result = 0x00 throughout.
REQ-023 Scenario: RST=1, X=1011 (-5), Y=1001 (-7), held 3 cycles -> final_result = 0x23 (+35).
REQ-024 Scenario: X=0110 (6), Y=1101 (-3) -> final_result = 0xEE (-18). Then X=1100 (-4), Y=1111 (-1) -> final_result = 0x04.
REQ-025 Scenario: corner cases X=1000, Y=1000 -> 0x40; X=0111, Y=1000 -> 0xC8 (-56); X=1000, Y=0111 -> 0xC8.
REQ-026 Scenario: a new operand pair every cycle across all 256 combinations -> each result matches the signed reference product, 3 edges after it was applied.
REQ-027 Scenario: RST pulsed low between edges with products in flight -> final_result = 0x00 at once. Recovery follows REQ-020.
